priority_scanner: RTL
=====================

# priority_scanner

Parametrised, sequential successor to the team's 8-bit combinational priority encoder. It accepts a WIDTH-bit request vector through a valid/ready handshake and emits the index of every set bit, one per handshake, highest index first, with a last-beat flag. It sits between request-collection logic and any consumer that services requests one at a time, such as an interrupt dispatcher or a bank scheduler.

## Interface
- WIDTH, default 8: width of the request vector; must be at least 2.
- IDX_W, default $clog2(WIDTH): width of the output index.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  acceptance enable; gates only in_ready, never an in-flight output.
- in_valid  input  1  in_vec is valid.
- in_ready  output  1  block can accept a vector.
- in_vec  input  WIDTH  request vector; bit k set means index k is requested.
- out_valid  output  1  out_idx is valid.
- out_ready  input  1  consumer accepts out_idx.
- out_idx  output  IDX_W  index of the highest set bit still pending.
- out_last  output  1  current beat is the final beat of this vector.
- out_zero  output  1  present only with PRIO_SCAN_ZERO_FLAG_EN; current beat reports an all-zero vector.

## Operation
- State register takes one of IDLE, SCAN or ZERO (ZERO exists only with the macro).
- A pend register, WIDTH bits wide, holds the requests not yet emitted.
- in_ready = en && (state == IDLE).
- An input transfer occurs when in_valid && in_ready.
  - On a transfer, pend <= in_vec.
  - If in_vec != 0, the next state is SCAN.
  - If in_vec == 0, the next state depends on the macro (see Configuration).
- In SCAN:
  - out_valid = 1.
  - out_idx = index of the most significant 1 in pend.
  - out_last = 1 when pend has exactly one bit set.
- An output transfer occurs when out_valid && out_ready.
  - On a transfer, the emitted bit of pend is cleared.
  - If out_last was set, the next state is IDLE and pend becomes 0.
- out_valid, once asserted, stays asserted with stable out_idx/out_last until the transfer. This holds regardless of en or in_valid.
- When out_valid is 0, out_idx = 0 and out_last = 0.
- Reset values: state IDLE, pend 0, out_valid 0, out_idx 0, out_last 0, out_zero 0. in_ready is 0 while rst is high and equals en from the first cycle after reset.
- Reset asserted mid-scan discards all pending bits. No further beats are emitted for that vector.

## Timing
- Latency: a vector accepted at edge t produces its first out_valid in the cycle after edge t.
- A vector with n set bits occupies n output beats at minimum. Each beat takes 1 cycle when out_ready is held high.
- There is a one-cycle bubble after the last beat. in_ready rises in the cycle after the final transfer, so a new vector is never accepted in the same cycle as a pop.
- No combinational path runs from in_* to out_*. All outputs depend only on registered state, except in_ready, which also depends on en.
- Simultaneous in_valid and out_valid are impossible to service together by construction: in_ready is 0 outside IDLE.

## Configuration
- Macro: PRIO_SCAN_ZERO_FLAG_EN.
- Defined:
  - The out_zero port exists.
  - An accepted all-zero vector moves the block to ZERO.
  - In ZERO, out_valid = 1, out_idx = 0, out_last = 1, out_zero = 1.
  - The transfer returns the block to IDLE.
  - out_zero is 0 in every other state.
- Undefined:
  - No out_zero port and no ZERO state.
  - An all-zero vector is accepted and dropped; the state stays IDLE and no beat is emitted.

## Structure
- Package prio_scan_pkg holds:
  - typedef enum for the states (IDLE, SCAN, ZERO);
  - a localparam for the state encoding width;
  - a function computing the index width from WIDTH.
- Sub-module prio_enc_msb (parameter WIDTH) is purely combinational.
  - Inputs: vec.
  - Outputs: idx (most significant set bit) and any (OR of vec).
  - priority_scanner instantiates it on pend.
- The onehot-last test is implemented in the top module as pend & (pend - 1) == 0 with pend != 0.

## Test plan
- WIDTH=8, en=1, in_vec=8'b1010_0101, out_ready=1 -> out_idx sequence 7, 5, 2, 0 on four consecutive cycles, with out_last only on idx 0; in_ready back to 1 one cycle later.
- Same vector, out_ready toggled 1,0,0,1,1,0,1 -> out_idx/out_last hold stable while stalled, and the same 7, 5, 2, 0 order is delivered.
- en=0 with in_valid=1 for 5 cycles -> in_ready=0 and no acceptance; raise en during SCAN of 8'h81 -> beats 7 then 0 are unaffected.
- rst pulsed after the first beat of 8'hFF -> next cycle out_valid=0, state IDLE; the following vector 8'h02 yields a single beat, idx 1 with last=1.
- in_vec=8'h00 -> with the macro: one beat, out_zero=1, out_idx=0, out_last=1; without it: no beat, and in_ready stays 1.
- WIDTH=32, in_vec=32'h8000_0001 -> beats 31 then 0; IDX_W=5 verified.

Source files
------------

// File: rtl/priority_scanner_pkg.sv
// prio_scan_pkg: shared types and helpers for the priority scanner.
// State encoding, its width, and the index-width helper used to size out_idx.
// Optional feature macro used by the block: PRIO_SCAN_ZERO_FLAG_EN.
package prio_scan_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ZERO = 2'd2
    } scan_state_t;

    // Number of bits needed to name any bit position of a WIDTH-bit vector.
    function automatic int idx_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/priority_scanner_enc.sv
// prio_enc_msb: purely combinational most-significant-set-bit encoder.
// idx is the position of the highest 1 in vec (0 when vec is empty), any is the OR of vec.
module prio_enc_msb #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk upward so the highest set bit is the last one to write idx.
    always_comb begin
        idx = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (vec[k]) begin
                idx = IDX_W'(k);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/priority_scanner.sv
// priority_scanner: accepts a request vector over valid/ready and emits the index
// of every set bit, highest first, one per output handshake, with a last-beat flag.
// Optional feature macro: PRIO_SCAN_ZERO_FLAG_EN adds the out_zero port and a
// ZERO state that reports an accepted all-zero vector as a single flagged beat.
module priority_scanner
    import prio_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = idx_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
`ifdef PRIO_SCAN_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    scan_state_t      state;
    logic [WIDTH-1:0] pend;
    logic [WIDTH-1:0] pend_minus_one;
    logic [WIDTH-1:0] clear_mask;
    logic [IDX_W-1:0] msb_idx;
    logic             pend_any;
    logic             pend_last;
    logic             in_fire;
    logic             out_fire;

    prio_enc_msb #(
        .WIDTH(WIDTH),
        .IDX_W(IDX_W)
    ) u_enc (
        .vec(pend),
        .idx(msb_idx),
        .any(pend_any)
    );

    // Exactly one bit left means the current beat is the final one for this vector.
    assign pend_minus_one = pend - WIDTH'(1);
    assign pend_last      = pend_any && ((pend & pend_minus_one) == '0);

    // One-hot mask of the bit being emitted, used to retire it on a pop.
    always_comb begin
        clear_mask          = '0;
        clear_mask[msb_idx] = 1'b1;
    end

    assign in_ready = en && !rst && (state == IDLE);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Output beat is decoded purely from registered state so nothing from in_* reaches out_*.
    always_comb begin
        out_valid = 1'b0;
        out_idx   = '0;
        out_last  = 1'b0;
`ifdef PRIO_SCAN_ZERO_FLAG_EN
        out_zero  = 1'b0;
`endif
        case (state)
            SCAN: begin
                out_valid = 1'b1;
                out_idx   = msb_idx;
                out_last  = pend_last;
            end
`ifdef PRIO_SCAN_ZERO_FLAG_EN
            ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_zero  = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Accept a vector in IDLE, retire one pending bit per output transfer, return to IDLE after the last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        pend <= in_vec;
                        if (|in_vec) begin
                            state <= SCAN;
                        end
`ifdef PRIO_SCAN_ZERO_FLAG_EN
                        else begin
                            state <= ZERO;
                        end
`endif
                    end
                end
                SCAN: begin
                    if (out_fire) begin
                        if (pend_last) begin
                            state <= IDLE;
                            pend  <= '0;
                        end else begin
                            pend <= pend & ~clear_mask;
                        end
                    end
                end
`ifdef PRIO_SCAN_ZERO_FLAG_EN
                ZERO: begin
                    if (out_fire) begin
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    pend  <= '0;
                end
            endcase
        end
    end

endmodule
